// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1_SYNC slice as an N-tap multiply-accumulate
// engine. It accepts a start/length command, streams operand pairs into the
// slice, and steers opmode and clock enables so that each product lands in P at
// the right edge. The final P value is returned over a result handshake.
//
// Handshake semantics (operand and result sides alike): a transfer happens on
// a rising CLK edge where valid and ready are both high. The producer holds
// valid and data stable until that edge. in_ready depends only on state, never
// on in_valid. result_valid stays high, with result held, until the consumer
// raises result_ready.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_ceopmode,
  input  logic [47:0]      dsp_p,
  output logic             busy,
  output logic             len_err,
  output logic [47:0]      result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // drain_cnt holds values up to PIPE_LAT-1
  localparam int DRAIN_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);

  // Opmode words: X mux in [1:0], Z mux in [3:2]
  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0: restart the accumulator
  localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P: accumulate
  localparam logic [7:0] OP_HOLD  = 8'h08;  // X=0, Z=P: P keeps its value

  logic [1:0]         state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               ce_en;
  logic               accept;
  logic               last_accept;

  // Handshake decode and pass-through of operands to the slice
  always_comb begin
    in_ready     = (state == S_RUN);
    accept       = in_valid & in_ready;
    last_accept  = accept && (cnt == (len_q - LEN_W'(1)));
    busy         = (state != S_IDLE);
    dsp_a        = in_a;
    dsp_b        = in_b;
    dsp_cea      = accept;
    dsp_ceb      = accept;
    dsp_cem      = ce_en;
    dsp_cep      = ce_en;
    dsp_ceopmode = ce_en;
    state_dbg    = state;
  end

  // M, P and OPMODE registers run continuously once out of reset
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) ce_en <= 1'b0;
    else        ce_en <= 1'b1;
  end

  // Command FSM: burst counting, pipeline drain and result capture
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_q        <= '0;
      cnt          <= '0;
      drain_cnt    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              len_err <= 1'b1;
            end else begin
              len_q <= len;
              cnt   <= '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (last_accept) begin
              drain_cnt <= DRAIN_W'(PIPE_LAT - 1);
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            result       <= dsp_p;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Opmode for the slice, one edge ahead of its OPMODE register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      dsp_opmode <= OP_IDLE;
    end else if (accept) begin
      dsp_opmode <= (cnt == '0) ? OP_FIRST : OP_ACC;
    end else if (state == S_RUN || state == S_DRAIN) begin
      dsp_opmode <= OP_HOLD;
    end else begin
      dsp_opmode <= OP_IDLE;
    end
  end

endmodule
